n4_b2_divider_seq: RTL and testbench

- Sequential restoring divider in base 2: computes x / y on N-bit unsigned operands, producing quotient q and remainder r.
- Inverse counterpart of the ripple-carry adder datapath: repeated trial subtraction, one quotient bit per clock.
- Sits beside the adder/subtractor blocks in the arithmetic library. Driven by a start/done handshake from a controlling unit.

---
 rtl/arith_pkg.sv | 10 +
 rtl/b2_adder.sv | 13 +
 rtl/b2_sub_step.sv | 28 ++
 rtl/n4_b2_divider_seq.sv | 104 ++++++++++
 tb/tb_n4_b2_divider_seq.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
// Shared constants for the arithmetic library: controller state encoding and default width.
package arith_pkg;

  localparam int unsigned N_DEFAULT = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/b2_adder.sv
// One-bit full adder cell used to build ripple-carry datapaths.
module b2_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/b2_sub_step.sv
// Combinational (N+1)-bit trial subtract a - {0,b}: ripple of b2_adder cells, b inverted, cin = 1.
module b2_sub_step #(
  parameter int N = 4
) (
  input  logic [N:0]   a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         neg
);

  logic [N:0] c;

  assign c[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_bit
    b2_adder u_add (
      .a   (a[i]),
      .b   (~b[i]),
      .cin (c[i]),
      .sum (diff[i]),
      .cout(c[i+1])
    );
  end

  // The divisor's top bit is an implicit 0, so its inverted form is 1.
  assign neg = a[N] ^ ~c[N];

endmodule

// File: rtl/n4_b2_divider_seq.sv
// Sequential restoring divider, one quotient bit per clock with a start/done handshake.
// Define DIV_ZERO_FAST_EN to skip the iteration when the divisor is zero.
module n4_b2_divider_seq
  import arith_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         div_zero
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  p_q;
  logic [N-1:0]  d_q;
  logic [N-1:0]  y_q;
  logic [N-1:0]  quo_q;

  logic [N:0]    p_shift;
  logic [N-1:0]  diff;
  logic          neg;

  assign p_shift = {p_q, d_q[N-1]};
  assign busy    = (state == ST_RUN);

  b2_sub_step #(
    .N(N)
  ) u_sub (
    .a   (p_shift),
    .b   (y_q),
    .diff(diff),
    .neg (neg)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      p_q      <= '0;
      d_q      <= '0;
      y_q      <= '0;
      quo_q    <= '0;
      q        <= '0;
      r        <= '0;
      div_zero <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            y_q   <= y;
            d_q   <= x;
            p_q   <= '0;
            quo_q <= '0;
            cnt   <= '0;
`ifdef DIV_ZERO_FAST_EN
            if (y == '0) begin
              // Preload the values a full zero-divisor iteration would converge to.
              quo_q <= '1;
              p_q   <= x;
              state <= ST_DONE;
            end else begin
              state <= ST_RUN;
            end
`else
            state <= ST_RUN;
`endif
          end
        end
        ST_RUN: begin
          // Partial remainder always fits N bits after the restore decision.
          p_q   <= neg ? p_shift[N-1:0] : diff;
          d_q   <= {d_q[N-2:0], 1'b0};
          quo_q <= {quo_q[N-2:0], ~neg};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          q        <= quo_q;
          r        <= p_q;
          div_zero <= (y_q == '0);
          done     <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_n4_b2_divider_seq.sv
// Self-checking bench: arithmetic reference model checked every cycle plus literal spot checks.
module tb_n4_b2_divider_seq;

  localparam int N = 4;
`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] x = '0;
  logic [N-1:0] y = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         div_zero;

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  n4_b2_divider_seq #(
    .N(N)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .x       (x),
    .y       (y),
    .busy    (busy),
    .done    (done),
    .q       (q),
    .r       (r),
    .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: t counts cycles since the accepted start, -1 when idle.
  int           t = -1;
  logic [N-1:0] mx, my, mq, mr;
  logic         mdz, mdone;

  function automatic bit m_fast();
    return FAST && (my == 0);
  endfunction

  function automatic bit m_busy();
    return (t >= 0) && (t < N) && !m_fast();
  endfunction

  always @(posedge clock) begin
    mdone = 1'b0;
    if (reset) begin
      t = -1; mq = '0; mr = '0; mdz = 1'b0;
    end else if (t < 0) begin
      if (start) begin
        mx = x; my = y; t = 0;
      end
    end else begin
      t++;
      if (t == (m_fast() ? 1 : N + 1)) begin
        if (my == 0) begin
          mq = '1; mr = mx; mdz = 1'b1;
        end else begin
          mq = mx / my; mr = mx % my; mdz = 1'b0;
        end
        mdone = 1'b1;
        t = -1;
      end
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      chk("busy", 32'(busy), 32'(m_busy()));
      chk("done", 32'(done), 32'(mdone));
      chk("q", 32'(q), 32'(mq));
      chk("r", 32'(r), 32'(mr));
      chk("div_zero", 32'(div_zero), 32'(mdz));
    end
  end

  // Issues one division; b2b skips the idle cycle so start lands in the done cycle.
  task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b, input bit b2b,
                         output logic [N-1:0] qq, output logic [N-1:0] rr,
                         output logic dz, output int lat);
    int cycles;
    if (!b2b) @(negedge clock);
    start = 1'b1; x = a; y = b;
    @(negedge clock);
    start = 1'b0;
    cycles = 1;
    while (!done && cycles < 40) begin
      @(negedge clock);
      cycles++;
    end
    if (!done) chk("done_timeout", 32'(cycles), 32'(0));
    lat = cycles; qq = q; rr = r; dz = div_zero;
  endtask

  logic [N-1:0] rq, rrm;
  logic         rdz;
  int           lat;

  initial begin
    @(posedge clock);
    @(negedge clock);
    checking = 1'b1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_q", 32'(q), 32'd0);
    reset = 1'b0;

    run_div(4'd13, 4'd3, 1'b0, rq, rrm, rdz, lat);
    chk("13/3 q", 32'(rq), 32'd4);
    chk("13/3 r", 32'(rrm), 32'd1);
    chk("13/3 dz", 32'(rdz), 32'd0);
    chk("13/3 latency", 32'(lat), 32'd6);

    run_div(4'd15, 4'd1, 1'b0, rq, rrm, rdz, lat);
    chk("15/1 q", 32'(rq), 32'd15);
    chk("15/1 r", 32'(rrm), 32'd0);
    run_div(4'd3, 4'd9, 1'b1, rq, rrm, rdz, lat);
    chk("3/9 q", 32'(rq), 32'd0);
    chk("3/9 r", 32'(rrm), 32'd3);
    chk("3/9 b2b latency", 32'(lat), 32'd6);

    run_div(4'd7, 4'd0, 1'b0, rq, rrm, rdz, lat);
    chk("7/0 q", 32'(rq), 32'd15);
    chk("7/0 r", 32'(rrm), 32'd7);
    chk("7/0 dz", 32'(rdz), 32'd1);
    chk("7/0 latency", 32'(lat), FAST ? 32'd2 : 32'd6);

    // Requests during RUN and in the DONE cycle must be ignored.
    @(negedge clock);
    start = 1'b1; x = 4'd10; y = 4'd2;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      if (c == 1) start = 1'b0;
      if (c == 2) begin start = 1'b1; x = 4'd1; y = 4'd1; end
      if (c == 3) start = 1'b0;
      if (c == 5) start = 1'b1;
      if (c == 6) begin
        start = 1'b0;
        chk("10/2 done", 32'(done), 32'd1);
        chk("10/2 q", 32'(q), 32'd5);
        chk("10/2 r", 32'(r), 32'd0);
      end
    end
    repeat (2) @(negedge clock);
    chk("ignored start idle", 32'(busy), 32'd0);

    // Reset in the second RUN cycle aborts the division.
    @(negedge clock);
    start = 1'b1; x = 4'd9; y = 4'd4;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort q", 32'(q), 32'd0);
    chk("abort r", 32'(r), 32'd0);
    chk("abort dz", 32'(div_zero), 32'd0);
    run_div(4'd9, 4'd4, 1'b0, rq, rrm, rdz, lat);
    chk("9/4 q", 32'(rq), 32'd2);
    chk("9/4 r", 32'(rrm), 32'd1);

    for (int xi = 0; xi < 16; xi++) begin
      for (int yi = 0; yi < 16; yi++) begin
        int gap;
        gap = $urandom_range(0, 2);
        repeat (gap) @(negedge clock);
        run_div(4'(xi), 4'(yi), gap == 0, rq, rrm, rdz, lat);
        if (yi != 0) begin
          chk("sweep q*y+r", 32'(int'(rq) * yi + int'(rrm)), 32'(xi));
          chk("sweep r<y", 32'(int'(rrm) < yi), 32'd1);
        end else begin
          chk("sweep y0 q", 32'(rq), 32'd15);
          chk("sweep y0 r", 32'(rrm), 32'(xi));
        end
      end
    end

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
